// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a counted, XOR-checksummed byte stream
// into big-endian 16-bit words written at even byte addresses, holding the CPU in reset until verified.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CNT_HI = 4'd1,
    S_CNT_LO = 4'd2,
    S_DAT_HI = 4'd3,
    S_DAT_LO = 4'd4,
    S_WRITE  = 4'd5,
    S_CHK    = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [ADDR_W:0] index_q, index_d, index_inc_s;
  logic [7:0]      xor_q, xor_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            in_ready_q, busy_q, done_q, err_q, cpu_rst_n_q;
  logic            accept_s;
  logic [15:0]     n_s;

  assign accept_s    = in_valid & in_ready_q;
  assign n_s         = {count_q[15:8], in_data};
  assign index_inc_s = index_q + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state and datapath decode for the stream parser.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    xor_d   = xor_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_CNT_HI;
          count_d = 16'd0;
          index_d = '0;
          xor_d   = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_CNT_HI: begin
        if (accept_s) begin
          count_d = {in_data, 8'd0};
          xor_d   = xor_q ^ in_data;
          state_d = S_CNT_LO;
        end else begin
          state_d = S_CNT_HI;
        end
      end
      S_CNT_LO: begin
        if (accept_s) begin
          count_d = n_s;
          xor_d   = xor_q ^ in_data;
          index_d = '0;
          if ({1'b0, n_s} > DEPTH) begin
            state_d = S_ERR;
          end else if (n_s == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DAT_HI;
          end
        end else begin
          state_d = S_CNT_LO;
        end
      end
      S_DAT_HI: begin
        if (accept_s) begin
          hi_d    = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_DAT_LO;
        end else begin
          state_d = S_DAT_HI;
        end
      end
      S_DAT_LO: begin
        if (accept_s) begin
          xor_d   = xor_q ^ in_data;
          we_d    = 1'b1;
          addr_d  = 16'({index_q, 1'b0});
          wdata_d = {hi_q, in_data};
          state_d = S_WRITE;
        end else begin
          state_d = S_DAT_LO;
        end
      end
      S_WRITE: begin
        index_d = index_inc_s;
        if (16'(index_inc_s) == count_q) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DAT_HI;
        end
      end
      S_CHK: begin
        if (accept_s) begin
          if (in_data == xor_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= 16'd0;
      index_q     <= '0;
      xor_q       <= 8'd0;
      hi_q        <= 8'd0;
      addr_q      <= 16'd0;
      wdata_q     <= 16'd0;
      we_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      xor_q       <= xor_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      in_ready_q  <= (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                     (state_d == S_DAT_HI) || (state_d == S_DAT_LO) ||
                     (state_d == S_CHK);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
      cpu_rst_n_q <= (state_d == S_DONE);
    end
  end

  assign in_ready    = in_ready_q;
  assign im_we       = we_q;
  assign im_addr     = addr_q;
  assign im_wdata    = wdata_q;
  assign cpu_reset_n = cpu_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand sequences and randomized
// loads checked against a stream-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (im_we) got_q.push_back({im_addr, im_wdata});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: interpret the stream by its format rules.
  task automatic model(input logic [7:0] b[$], output int used, output bit e_done,
                       output bit e_err, output logic [31:0] e_wr[$]);
    int n;
    logic [7:0] x;
    e_wr.delete();
    n = int'({b[0], b[1]});
    if (n > 256) begin
      used = 2; e_done = 1'b0; e_err = 1'b1;
    end else begin
      x = 8'd0;
      for (int i = 0; i < 2*n + 2; i++) x = x ^ b[i];
      for (int w = 0; w < n; w++) e_wr.push_back({16'(2*w), b[2+2*w], b[3+2*w]});
      used   = 2*n + 3;
      e_done = (b[2*n+2] == x);
      e_err  = !e_done;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr", 32'(err), 32'd0);
    chk("start_cpu_held", 32'(cpu_reset_n), 32'd0);
  endtask

  // mode 0: in_valid always high, 1: 1-0-0-1 pattern, 2: random gaps
  task automatic send(input logic [7:0] s[$], input int mode);
    int i = 0;
    int k = 0;
    bit v;
    while (i < s.size() && k < 5000) begin
      @(negedge clk);
      case (mode)
        1:       v = (k % 4 == 0) || (k % 4 == 3);
        2:       v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      k++;
      in_valid = v;
      in_data  = v ? s[i] : 8'($urandom);
      if (v && in_ready) i++;
    end
    if (i < s.size()) begin
      total++; bad++;
      $display("FAIL send_timeout actual=%0d required=%0d bytes", i, s.size());
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] b[$], input int mode, output int nwr);
    int used;
    bit ed, ee;
    logic [31:0] ew[$];
    logic [7:0] s[$];
    model(b, used, ed, ee, ew);
    for (int i = 0; i < used; i++) s.push_back(b[i]);
    got_q.delete();
    pulse_start();
    send(s, mode);
    chk("res_done", 32'(done), 32'(ed));
    chk("res_err", 32'(err), 32'(ee));
    chk("res_cpu_rst_n", 32'(cpu_reset_n), 32'(ed));
    chk("res_busy", 32'(busy), 32'd0);
    chk("res_in_ready", 32'(in_ready), 32'd0);
    chk("res_nwr", 32'(got_q.size()), 32'(ew.size()));
    for (int i = 0; i < got_q.size() && i < ew.size(); i++) chk("res_write", got_q[i], ew[i]);
    nwr = got_q.size();
  endtask

  typedef struct {
    logic [7:0]  bytes [8];
    int          len;
    int          mode;
    bit          e_done;
    bit          e_err;
    int          e_nwr;
    logic [15:0] e_last;
  } vec_t;

  vec_t tab[6];

  initial begin
    logic [7:0] q[$];
    int nwr;
    int n;
    logic [7:0] x;

    tab[0] = '{'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h42,8'h00}, 7, 0, 1'b1, 1'b0, 2, 16'hABCD};
    tab[1] = '{'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h43,8'h00}, 7, 0, 1'b0, 1'b1, 2, 16'hABCD};
    tab[2] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 1'b1, 1'b0, 0, 16'h0000};
    tab[3] = '{'{8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b0, 1'b1, 0, 16'h0000};
    tab[4] = '{'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h42,8'h00}, 7, 1, 1'b1, 1'b0, 2, 16'hABCD};
    tab[5] = '{'{8'h00,8'h01,8'hFF,8'h00,8'hFE,8'h00,8'h00,8'h00}, 5, 0, 1'b1, 1'b0, 1, 16'hFF00};

    // reset held low for two cycles with random inputs
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start = 1'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", 32'(im_wdata), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_reset_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_no_writes", 32'(got_q.size()), 32'd0);
    start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    reset = 1'b1;
    @(negedge clk);

    // table-driven loads
    for (int k = 0; k < 6; k++) begin
      q.delete();
      for (int i = 0; i < tab[k].len; i++) q.push_back(tab[k].bytes[i]);
      run_load(q, tab[k].mode, nwr);
      chk("tab_done", 32'(done), 32'(tab[k].e_done));
      chk("tab_err", 32'(err), 32'(tab[k].e_err));
      chk("tab_nwr", 32'(nwr), 32'(tab[k].e_nwr));
      if (tab[k].e_nwr > 0 && got_q.size() > 0) chk("tab_last", 32'(got_q[$][15:0]), 32'(tab[k].e_last));
    end

    // start mid-load is ignored
    got_q.delete();
    pulse_start();
    q = '{8'h00, 8'h02, 8'h12};
    send(q, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("midstart_busy", 32'(busy), 32'd1);
    q = '{8'h34, 8'hAB, 8'hCD, 8'h42};
    send(q, 0);
    chk("midstart_done", 32'(done), 32'd1);
    chk("midstart_nwr", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) chk("midstart_wr1", got_q[1], 32'h0002ABCD);

    // full-capacity image, N == DEPTH
    q.delete();
    q.push_back(8'h01); q.push_back(8'h00);
    x = 8'h01;
    for (int i = 0; i < 512; i++) begin
      q.push_back(8'($urandom));
      x = x ^ q[$];
    end
    q.push_back(x);
    run_load(q, 0, nwr);
    if (got_q.size() == 256) chk("full_last_addr", 32'(got_q[255][31:16]), 32'h01FE);

    // randomized loads
    for (int r = 0; r < 25; r++) begin
      q.delete();
      n = ($urandom_range(0, 4) == 0) ? 257 + int'($urandom_range(0, 4000)) : int'($urandom_range(0, 6));
      q.push_back(8'(n >> 8)); q.push_back(8'(n));
      if (n <= 256) begin
        x = q[0] ^ q[1];
        for (int i = 0; i < 2*n; i++) begin
          q.push_back(8'($urandom));
          x = x ^ q[$];
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        q.push_back(x);
      end
      run_load(q, int'($urandom_range(0, 2)), nwr);
    end

    // reset between payload bytes
    got_q.delete();
    pulse_start();
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send(q, 0);
    @(negedge clk); reset = 1'b0; in_valid = 1'b1; in_data = 8'hCD;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_cpu", 32'(cpu_reset_n), 32'd0);
    chk("midrst_addr", 32'(im_addr), 32'd0);
    chk("midrst_wdata", 32'(im_wdata), 32'd0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_nwr", 32'(got_q.size()), 32'd1);
    chk("midrst_idle_ready", 32'(in_ready), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
